// File: rtl/fifo_rr_arbiter_if.sv
// Handshake bundle between fifo_rr_arbiter, its N_CH source fifos and the
// downstream consumer of the merged stream.
interface fifo_rr_arbiter_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 24
);
  localparam int unsigned CW = $clog2(N_CH);

  logic                  en;
  logic [N_CH-1:0]       ch_mask;
  logic [N_CH-1:0]       ch_empty;
  logic [N_CH*WIDTH-1:0] ch_dout;
  logic [N_CH-1:0]       ch_rd;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [CW-1:0]         out_ch;
  logic                  busy;

  modport master (
    input  en, ch_mask, ch_empty, ch_dout, out_ready,
    output ch_rd, out_valid, out_data, out_ch, busy
  );

  modport slave (
    output en, ch_mask, ch_empty, ch_dout, out_ready,
    input  ch_rd, out_valid, out_data, out_ch, busy
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin read scheduler: sole reader of N_CH registered-output fifos,
// merges them into one valid/ready stream tagged with the source channel.
module fifo_rr_arbiter #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 24,
  parameter int unsigned BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_rr_arbiter_if.master   bus
);
  localparam int unsigned CW = $clog2(N_CH);
  localparam int unsigned BW = $clog2(BURST + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_gnt;
  logic [CW-1:0]    r_ptr;
  logic [BW-1:0]    r_bcnt;
  logic [N_CH-1:0]  r_rd;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_ch;

  logic [N_CH-1:0]  w_elig;
  logic [CW-1:0]    w_gnt_nx;
  logic [CW-1:0]    w_sel_idle;
  logic [CW-1:0]    w_sel_out;
  logic [WIDTH-1:0] w_gnt_dout;
  logic             w_hs;
  logic             w_stay;

  // First set bit of e scanning s, s+1, ..., wrapping; later loop passes
  // overwrite earlier ones, so the lowest offset from s wins.
  function automatic logic [CW-1:0] rr_pick(input logic [N_CH-1:0] e,
                                            input logic [CW-1:0]   s);
    logic [CW-1:0] p;
    int unsigned   idx;
    logic [CW-1:0] ci;
    p = s;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = (32'(s) + N_CH - 1 - i) % N_CH;
      ci  = CW'(idx);
      if (e[ci]) p = ci;
    end
    return p;
  endfunction

  function automatic logic [N_CH-1:0] onehot(input logic [CW-1:0] i);
    logic [N_CH-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_comb begin
    w_elig     = bus.en ? (bus.ch_mask & ~bus.ch_empty) : '0;
    w_gnt_nx   = (r_gnt == CW'(N_CH - 1)) ? '0 : r_gnt + CW'(1);
    w_sel_idle = rr_pick(w_elig, r_ptr);
    w_sel_out  = rr_pick(w_elig, w_gnt_nx);
    w_gnt_dout = bus.ch_dout[r_gnt*WIDTH +: WIDTH];
    w_hs       = r_valid & bus.out_ready;
    w_stay     = (r_bcnt < BW'(BURST)) & w_elig[r_gnt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_bcnt  <= '0;
      r_rd    <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_elig) begin
            r_gnt   <= w_sel_idle;
            r_bcnt  <= '0;
            r_rd    <= onehot(w_sel_idle);
            r_state <= S_RD;
          end
        end
        S_RD: begin
          r_rd    <= '0;
          r_state <= S_CAP;
        end
        // fifo dout was updated by the read edge; it is stable here
        S_CAP: begin
          r_data  <= w_gnt_dout;
          r_ch    <= r_gnt;
          r_valid <= 1'b1;
          r_bcnt  <= r_bcnt + BW'(1);
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            if (w_stay) begin
              r_rd    <= onehot(r_gnt);
              r_state <= S_RD;
            end else begin
              r_ptr <= w_gnt_nx;
              if (|w_elig) begin
                r_gnt   <= w_sel_out;
                r_bcnt  <= '0;
                r_rd    <= onehot(w_sel_out);
                r_state <= S_RD;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ch_rd     = r_rd;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_ch    = r_ch;
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: behavioural fifos, a transaction-level
// round-robin/burst model and a scoreboard checked on every valid output cycle.
module tb_fifo_rr_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 24;
  localparam int unsigned B = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_rr_arbiter_if #(.N_CH(N), .WIDTH(W)) bus ();

  fifo_rr_arbiter #(.N_CH(N), .WIDTH(W), .BURST(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] fq [N][$];
  logic [W-1:0] sb [N][$];
  int           log_q [$];

  logic         wr_v = 1'b0;
  int unsigned  wr_k = 0;
  logic [W-1:0] wr_d = '0;

  // Behavioural fifos: registered dout, rd pops on the clock edge.
  always @(posedge clk) begin
    logic [W-1:0] tmp;
    int unsigned  ri;
    if (bus.ch_rd != '0) begin
      ri = 0;
      for (int k = 0; k < N; k++) if (bus.ch_rd[k]) ri = k;
      checks++;
      if (!$onehot(bus.ch_rd) || fq[ri].size() == 0) begin
        errors++;
        $display("FAIL rd_legal: got ch_rd=%b with fifo size %0d, expected one-hot read of a non-empty fifo",
                 bus.ch_rd, fq[ri].size());
      end else begin
        tmp = fq[ri].pop_front();
        bus.ch_dout[ri*W +: W] <= tmp;
      end
    end
    if (wr_v) begin
      fq[wr_k].push_back(wr_d);
      sb[wr_k].push_back(wr_d);
    end
    for (int k = 0; k < N; k++) bus.ch_empty[k] <= (fq[k].size() == 0);
  end

  // Transaction-level model of the scheduling rules plus scoreboard.
  logic        m_active = 1'b0;
  logic        m_seen   = 1'b0;
  int unsigned m_cur    = 0;
  int unsigned m_ptr    = 0;
  int unsigned m_cnt    = 0;

  function automatic int unsigned pick(input logic [N-1:0] e, input int unsigned s);
    for (int unsigned i = 0; i < N; i++) begin
      if (e[(s + i) % N]) return (s + i) % N;
    end
    return s;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    logic [N-1:0] e;
    logic [W-1:0] exp_d;
    logic         have;
    if (!rst_n) begin
      if (m_active && m_seen && sb[m_cur].size() > 0) void'(sb[m_cur].pop_front());
      m_active = 1'b0;
      m_seen   = 1'b0;
      m_ptr    = 0;
      m_cnt    = 0;
    end else begin
      e = bus.en ? (bus.ch_mask & ~bus.ch_empty) : '0;
      if (!m_active) begin
        if (bus.out_valid) begin
          errors++;
          $display("FAIL idle_valid: got out_valid=1, expected 0 while no grant is pending");
        end
        if (e != '0) begin
          m_cur    = pick(e, m_ptr);
          m_cnt    = 0;
          m_active = 1'b1;
        end
      end else if (bus.out_valid) begin
        m_seen = 1'b1;
        have   = (sb[m_cur].size() > 0);
        exp_d  = have ? sb[m_cur][0] : '0;
        checks++;
        if (!have || bus.out_ch != m_cur[$clog2(N)-1:0] || bus.out_data != exp_d) begin
          errors++;
          $display("FAIL out_word: got ch=%0d data=0x%0h, expected ch=%0d data=0x%0h (queued=%0d)",
                   bus.out_ch, bus.out_data, m_cur, exp_d, have);
        end
        if (bus.out_ready) begin
          if (have) void'(sb[m_cur].pop_front());
          log_q.push_back(int'(m_cur));
          m_cnt++;
          m_seen = 1'b0;
          if (!(m_cnt < B && e[m_cur])) begin
            m_ptr = (m_cur + 1) % N;
            if (e != '0) begin
              m_cur = pick(e, m_ptr);
              m_cnt = 0;
            end else begin
              m_active = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int unsigned k, input logic [W-1:0] d);
    wr_v = 1'b1; wr_k = k; wr_d = d;
    cyc(1);
    wr_v = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget);
    while (log_q.size() < n && budget > 0) begin
      cyc(1);
      budget--;
    end
    chk("wait_log_timeout", 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    do begin
      @(negedge clk);
      budget--;
    end while (!bus.out_valid && budget > 0);
    chk("wait_valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic wait_rd(input int budget);
    do begin
      @(negedge clk);
      budget--;
    end while (bus.ch_rd == '0 && budget > 0);
  endtask

  task automatic wait_drained(input int budget);
    while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && budget > 0) begin
      cyc(1);
      budget--;
    end
    chk("drain_timeout", 32'(budget > 0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp3 [8] = '{1, 1, 1, 1, 2, 2, 1, 1};
    int exp5 [3] = '{3, 0, 1};
    int n0;
    int rd_pulses;

    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.ch_mask   = '1;
    bus.out_ready = 1'b1;
    bus.ch_empty  = '1;
    bus.ch_dout   = '0;
    cyc(3);
    chk("reset_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_data",  32'(bus.out_data),  32'd0);
    chk("reset_ch",    32'(bus.out_ch),    32'd0);
    chk("reset_rd",    32'(bus.ch_rd),     32'd0);
    chk("reset_busy",  32'(bus.busy),      32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Single word and latency
    bus.en = 1'b1;
    wr(0, 24'hABCDEF);
    wait_rd(10);
    chk("single_rd", 32'(bus.ch_rd), 32'h1);
    @(negedge clk);
    chk("single_rd_one_cycle", 32'(bus.ch_rd), 32'h0);
    chk("single_cap_novalid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_data",  32'(bus.out_data),  32'hABCDEF);
    chk("single_ch",    32'(bus.out_ch),    32'd0);
    @(negedge clk);
    chk("single_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("single_idle",       32'(bus.busy),      32'd0);
    cyc(1);

    // Burst then rotate
    bus.en = 1'b0;
    for (int i = 1; i <= 6; i++) wr(1, 24'h100000 + 24'(i));
    for (int i = 1; i <= 2; i++) wr(2, 24'h200000 + 24'(i));
    log_q.delete();
    bus.en = 1'b1;
    wait_log(8, 200);
    for (int i = 0; i < 8; i++) chk("burst_seq", 32'(log_q.size() > i ? log_q[i] : -1), 32'(exp3[i]));

    // Backpressure
    bus.out_ready = 1'b0;
    n0 = log_q.size();
    wr(0, 24'h400001);
    wr(0, 24'h400002);
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_no_rd", 32'(bus.ch_rd), 32'h0);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    cyc(1);
    bus.out_ready = 1'b1;
    wait_drained(100);
    chk("bp_count", 32'(log_q.size() - n0), 32'd2);

    // Wrap and mask
    bus.ch_mask = 4'b0100;
    wr(2, 24'h500002);
    wait_drained(50);
    bus.en = 1'b0;
    bus.ch_mask = 4'b1011;
    for (int k = 0; k < 4; k++) wr(k, 24'h600000 + 24'(k));
    log_q.delete();
    bus.en = 1'b1;
    wait_log(3, 100);
    cyc(20);
    chk("mask_count", 32'(log_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("mask_seq", 32'(log_q.size() > i ? log_q[i] : -1), 32'(exp5[i]));
    chk("mask_ch2_untouched", 32'(sb[2].size()), 32'd1);
    bus.ch_mask = '1;
    wait_drained(50);

    // Disable during CAP
    bus.en = 1'b0;
    wr(3, 24'h700001);
    wr(3, 24'h700002);
    n0 = log_q.size();
    bus.en = 1'b1;
    wait_rd(20);
    cyc(1);
    bus.en = 1'b0;
    wait_log(n0 + 1, 20);
    rd_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ch_rd != '0) rd_pulses++;
    end
    chk("dis_no_rd", 32'(rd_pulses), 32'd0);
    chk("dis_idle", 32'(bus.busy), 32'd0);
    chk("dis_left", 32'(sb[3].size()), 32'd1);
    cyc(1);
    bus.en = 1'b1;
    wait_drained(50);

    // Asynchronous reset mid-OUT
    bus.en = 1'b0;
    bus.ch_mask = 4'b0100;
    wr(2, 24'h800001);
    wr(2, 24'h800002);
    wr(1, 24'h810001);
    wr(1, 24'h810002);
    wr(3, 24'h830001);
    bus.out_ready = 1'b0;
    bus.en = 1'b1;
    wait_valid(20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_rd",    32'(bus.ch_rd),     32'd0);
    chk("arst_busy",  32'(bus.busy),      32'd0);
    bus.ch_mask = '1;
    bus.out_ready = 1'b1;
    cyc(2);
    log_q.delete();
    rst_n = 1'b1;
    wait_log(1, 50);
    chk("arst_restart_ch", 32'(log_q.size() > 0 ? log_q[0] : -1), 32'd1);
    wait_drained(100);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      bus.en        = ($urandom_range(9) != 0);
      bus.out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(19) == 0) bus.ch_mask = N'($urandom);
      if ($urandom_range(9) < 4) wr($urandom_range(N - 1), W'($urandom));
      else cyc(1);
    end
    bus.en = 1'b1;
    bus.ch_mask = '1;
    bus.out_ready = 1'b1;
    wait_drained(3000);
    cyc(10);
    for (int k = 0; k < N; k++) chk("final_empty", 32'(sb[k].size()), 32'd0);
    chk("final_idle", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
